page_fifo: RTL and testbench

- Parametrised, sequencer-controlled word FIFO. It sits between the DDR controller's page output and the sequencer's 8-bit input registers.
- Lets the sequencer capture several controller pages, or build words byte-by-byte, then read them back one selectable byte at a time.
- Successor to the single-page register path: generalised in word width and depth, with staging, exchange and error flags.

---
 rtl/page_fifo.sv | 182 ++++++++++++++++++
 tb/tb_page_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/page_fifo.sv
// page_fifo: sequencer-controlled word FIFO between the DDR controller page
// output and the sequencer's 8-bit input registers. Words are pushed either
// straight from push_data (CAPTURE/XCHG) or from a byte-built staging word
// (LDB/PUSHS), and read back one selectable byte of the head entry at a time.
//
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   inst[11:0]        - [11:8] opcode, [7:0] immediate
//   inst_en           - instruction valid, sampled each rising edge
//   push_data         - word captured by CAPTURE / XCHG
//   byte_o            - byte sel of the head entry, 8'h00 when empty
//   count             - stored entries, 0..DEPTH
//   empty, full       - registered status
//   overflow          - sticky: a push was dropped because the FIFO was full
//   underflow         - sticky: a pop was issued on an empty FIFO
module page_fifo #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [11:0]           inst,
    input  logic                  inst_en,
    input  logic [WORD_WIDTH-1:0] push_data,
    output logic [7:0]            byte_o,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int NBYTES = WORD_WIDTH / 8;

    typedef enum logic [3:0] {
        OP_NOP     = 4'h0,
        OP_CAPTURE = 4'h1,
        OP_POP     = 4'h2,
        OP_SELB    = 4'h3,
        OP_CLR     = 4'h4,
        OP_LDB     = 4'h5,
        OP_PUSHS   = 4'h6,
        OP_XCHG    = 4'h7
    } op_e;

    typedef logic [NBYTES-1:0][7:0] word_t;

    word_t                 mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, full_q;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    word_t                 stage_q, stage_d;

    logic                  do_push, do_pop, do_clr;
    word_t                 push_word;
    logic [3:0]            opcode;
    logic [7:0]            imm;

    assign opcode = inst[11:8];
    assign imm    = inst[7:0];

    // Instruction decode: one instruction per cycle, so at most one push
    // source and one pop are active.
    always_comb begin
        do_push   = 1'b0;
        do_pop    = 1'b0;
        do_clr    = 1'b0;
        push_word = word_t'(push_data);
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        sel_d     = sel_q;
        stage_d   = stage_q;
        if (inst_en) begin
            case (opcode)
                OP_CAPTURE: begin
                    if (full_q) ovf_d = 1'b1;
                    else        do_push = 1'b1;
                end
                OP_POP: begin
                    if (empty_q) unf_d = 1'b1;
                    else         do_pop = 1'b1;
                end
                OP_SELB: sel_d = imm[SEL_WIDTH-1:0];
                OP_CLR: begin
                    do_clr = 1'b1;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                end
                OP_LDB: begin
                    for (int k = 0; k < NBYTES; k++)
                        if (sel_q == SEL_WIDTH'(k)) stage_d[k] = imm;
                end
                OP_PUSHS: begin
                    push_word = stage_q;
                    if (full_q) ovf_d = 1'b1;
                    else        do_push = 1'b1;
                end
                OP_XCHG: begin
                    // When full, wr_ptr == rd_ptr: the write lands in the
                    // slot being popped, so no overflow is possible.
                    do_push = 1'b1;
                    if (empty_q) unf_d  = 1'b1;
                    else         do_pop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pointer / count next state. count is its own register so full and
    // empty never alias on equal pointers.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            if (do_push && !do_pop) count_d = count_q + (ADDR_WIDTH+1)'(1);
            if (do_pop && !do_push) count_d = count_q - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sel_q    <= '0;
            stage_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == (ADDR_WIDTH+1)'(DEPTH));
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            sel_q    <= sel_d;
            stage_q  <= stage_d;
        end
    end

    // Storage has no reset; it is only observable through byte_o when the
    // FIFO is non-empty.
    always_ff @(posedge clock) begin
        if (!reset && do_push) mem[wr_ptr_q] <= push_word;
    end

    // Head byte select; an out-of-range sel (possible when WORD_WIDTH=8)
    // reads as zero.
    always_comb begin
        word_t head;
        head   = mem[rd_ptr_q];
        byte_o = 8'h00;
        if (!empty_q) begin
            for (int k = 0; k < NBYTES; k++)
                if (sel_q == SEL_WIDTH'(k)) byte_o = head[k];
        end
    end

    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_page_fifo.sv
module tb_page_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] inst;
    logic        inst_en;
    logic [31:0] push_data;
    logic [7:0]  byte_o;
    logic [3:0]  count;
    logic        empty, full, overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;

    page_fifo #(.WORD_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(3), .SEL_WIDTH(2)) dut (
        .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en),
        .push_data(push_data), .byte_o(byte_o), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    // Inputs change on the falling edge; the instruction is taken on the
    // following rising edge and results are sampled at the next falling edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] imm, input logic [31:0] d);
        inst      = {op, imm};
        push_data = d;
        inst_en   = 1'b1;
        @(negedge clock);
        inst_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; inst = '0; inst_en = 1'b0; push_data = '0;
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        idle(3);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_byte", 32'(byte_o), 32'h00);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        // single capture, byte walk
        issue(4'h1, 8'h00, 32'hDEADBEEF);
        chk("cap_count", 32'(count), 1);
        chk("cap_b0", 32'(byte_o), 32'hEF);
        issue(4'h3, 8'h01, 0); chk("selb1", 32'(byte_o), 32'hBE);
        issue(4'h3, 8'h02, 0); chk("selb2", 32'(byte_o), 32'hAD);
        issue(4'h3, 8'hFF, 0); chk("selb3_upper_ign", 32'(byte_o), 32'hDE);
        issue(4'h3, 8'h00, 0);
        issue(4'h2, 8'h00, 0);
        chk("pop_empty", 32'(empty), 1);
        chk("pop_byte0", 32'(byte_o), 32'h00);

        // overflow
        for (int i = 1; i <= 9; i++) begin
            issue(4'h1, 8'h00, 32'(i));
            if (i == 8) chk("ovf_not_yet", 32'(overflow), 0);
        end
        chk("ovf_full", 32'(full), 1);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_drain", 32'(byte_o), 32'(i));
            issue(4'h2, 8'h00, 0);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_unf0", 32'(underflow), 0);
        issue(4'h2, 8'h00, 0);
        chk("unf_flag", 32'(underflow), 1);
        chk("unf_count", 32'(count), 0);
        issue(4'h4, 8'h00, 0);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_unf", 32'(underflow), 0);

        // wrap and exchange
        for (int i = 0; i < 8; i++) issue(4'h1, 8'h00, 32'h10 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            chk("wrap_pop", 32'(byte_o), 32'h10 + 32'(i));
            issue(4'h2, 8'h00, 0);
        end
        chk("wrap_count3", 32'(count), 3);
        for (int i = 0; i < 5; i++) issue(4'h1, 8'h00, 32'h18 + 32'(i));
        chk("wrap_full", 32'(full), 1);
        chk("wrap_head", 32'(byte_o), 32'h15);
        issue(4'h7, 8'h00, 32'h1D);
        chk("xchg_count", 32'(count), 8);
        chk("xchg_ovf", 32'(overflow), 0);
        chk("xchg_unf", 32'(underflow), 0);
        for (int i = 0; i < 8; i++) begin
            chk("xchg_order", 32'(byte_o), 32'h16 + 32'(i));
            issue(4'h2, 8'h00, 0);
        end
        chk("xchg_drain_empty", 32'(empty), 1);

        // staging
        issue(4'h3, 8'h02, 0);
        issue(4'h5, 8'h5A, 0);
        issue(4'h3, 8'h00, 0);
        issue(4'h5, 8'hA5, 0);
        chk("stg_notpushed", 32'(count), 0);
        issue(4'h6, 8'h00, 0);
        chk("stg_count", 32'(count), 1);
        chk("stg_b0", 32'(byte_o), 32'hA5);
        issue(4'h3, 8'h01, 0); chk("stg_b1", 32'(byte_o), 32'h00);
        issue(4'h3, 8'h02, 0); chk("stg_b2", 32'(byte_o), 32'h5A);
        issue(4'h3, 8'h03, 0); chk("stg_b3", 32'(byte_o), 32'h00);

        // exchange on empty behaves as capture + underflow
        issue(4'h2, 8'h00, 0);
        issue(4'h7, 8'h00, 32'h11223344);
        chk("xe_count", 32'(count), 1);
        chk("xe_unf", 32'(underflow), 1);
        chk("xe_b3", 32'(byte_o), 32'h11);
        issue(4'h4, 8'h00, 0);
        chk("clr2_empty", 32'(empty), 1);
        chk("clr2_unf", 32'(underflow), 0);
        // CLR keeps sel (3) and the staging word
        issue(4'h6, 8'h00, 0);
        chk("stg_keep_b3", 32'(byte_o), 32'h00);
        issue(4'h3, 8'h02, 0);
        chk("stg_keep_b2", 32'(byte_o), 32'h5A);
        issue(4'h4, 8'h00, 0);

        // reset beats a coincident capture
        for (int i = 0; i < 3; i++) issue(4'h1, 8'h00, 32'hC0 + 32'(i));
        chk("pre_rst_count", 32'(count), 3);
        inst = 12'h100; push_data = 32'hAABBCCDD; inst_en = 1'b1; reset = 1'b1;
        @(negedge clock);
        inst_en = 1'b0; reset = 1'b0;
        chk("rstcap_count", 32'(count), 0);
        chk("rstcap_empty", 32'(empty), 1);
        chk("rstcap_byte", 32'(byte_o), 32'h00);
        issue(4'h6, 8'h00, 0);
        chk("rst_stage_zero", 32'(byte_o), 32'h00);
        issue(4'h2, 8'h00, 0);
        issue(4'h1, 8'h00, 32'hAABBCCDD);
        chk("rst_sel0", 32'(byte_o), 32'hDD);

        // CLR with overflow set
        for (int i = 0; i < 8; i++) issue(4'h1, 8'h00, 32'(i));
        chk("ovf2_flag", 32'(overflow), 1);
        issue(4'h4, 8'h00, 0);
        chk("clr3_ovf", 32'(overflow), 0);
        chk("clr3_empty", 32'(empty), 1);
        chk("clr3_count", 32'(count), 0);

        // undefined opcode and disabled instruction
        issue(4'hB, 8'hFF, 32'h12345678);
        chk("opB_count", 32'(count), 0);
        chk("opB_empty", 32'(empty), 1);
        inst = 12'h100; push_data = 32'h99; inst_en = 1'b0;
        @(negedge clock);
        chk("noen_count", 32'(count), 0);
        chk("noen_ovf", 32'(overflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
